// File: rtl/prefetch_fetcher.sv
// Instruction prefetch stage: streams sequential words from memory into a
// DEPTH-entry {pc, instr} queue and hands them to the decoder; redirect restarts fetch.
module prefetch_fetcher #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        decoder_ready,
  output logic        fetcher_valid,
  output logic [31:0] instr,
  output logic [31:0] fetcher_pc,
  output logic        mem_ready,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic          discard_q, discard_d;
  logic          push, pop, resp, space;
  logic [AW+1:0] cnt_nxt;
  logic [31:0]   redir_pc;

  assign redir_pc = {redirect_pc[31:2], 2'b00};

  always_comb begin
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    discard_d  = discard_q;
    pop        = (cnt_q != '0) && decoder_ready && !redirect;
    resp       = req_q && mem_valid;
    push       = resp && !discard_q && !redirect;
    cnt_nxt    = {1'b0, cnt_q} + {{(AW+1){1'b0}}, push} - {{(AW+1){1'b0}}, pop};
    space      = cnt_nxt < DEPTH_W;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    cnt_d = cnt_nxt[AW:0];
    if (redirect) begin
      cnt_d      = '0;
      rd_d       = wr_q;
      fetch_pc_d = redir_pc;
      // An in-flight request cannot be withdrawn: keep the strobe and drop its data later.
      if (!req_q || mem_valid) begin
        req_d     = 1'b1;
        addr_d    = redir_pc;
        discard_d = 1'b0;
      end else begin
        discard_d = 1'b1;
      end
    end else if (resp) begin
      if (discard_q) begin
        discard_d = 1'b0;
        req_d     = 1'b1;
        addr_d    = fetch_pc_q;
      end else begin
        fetch_pc_d = addr_q + 32'd4;
        req_d      = space;
        if (space) addr_d = addr_q + 32'd4;
      end
    end else if (!req_q && !discard_q && space) begin
      req_d  = 1'b1;
      addr_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      req_q      <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      discard_q  <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]  <= addr_q;
      ins_mem[wr_q] <= mem_rdata;
    end
  end

  assign fetcher_valid = (cnt_q != '0);
  assign instr         = fetcher_valid ? ins_mem[rd_q] : 32'h0;
  assign fetcher_pc    = fetcher_valid ? pc_mem[rd_q] : 32'h0;
  assign mem_ready     = req_q;
  assign mem_instr     = req_q;
  assign mem_addr      = addr_q;
  assign mem_wstrb     = 4'b0000;
endmodule
